// File: rtl/aes_inv_key_schedule_pkg.sv
// rtl/aes_inv_key_schedule_pkg.sv - AES tables, GF(2^8) helpers and FSM type for the reverse key schedule
package aes_inv_key_schedule_pkg;

  localparam int ROUNDS = 10;
  localparam int RK_W   = 128;

  typedef enum logic {IDLE, EMIT} inv_ks_state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
    logic [7:0] s0, s1, s2, s3;
    {s0, s1, s2, s3} = c;
    return {gmul(s0, 8'h0e) ^ gmul(s1, 8'h0b) ^ gmul(s2, 8'h0d) ^ gmul(s3, 8'h09),
            gmul(s0, 8'h09) ^ gmul(s1, 8'h0e) ^ gmul(s2, 8'h0b) ^ gmul(s3, 8'h0d),
            gmul(s0, 8'h0d) ^ gmul(s1, 8'h09) ^ gmul(s2, 8'h0e) ^ gmul(s3, 8'h0b),
            gmul(s0, 8'h0b) ^ gmul(s1, 8'h0d) ^ gmul(s2, 8'h09) ^ gmul(s3, 8'h0e)};
  endfunction

endpackage

// File: rtl/aes_inv_key_schedule_if.sv
// rtl/aes_inv_key_schedule_if.sv - start/load and round-key handshake bundle for the reverse key schedule
interface aes_inv_key_schedule_if;
  import aes_inv_key_schedule_pkg::*;

  logic            start;
  logic [RK_W-1:0] last_key;
  logic            busy;
  logic            rk_valid;
  logic            rk_ready;
  logic [RK_W-1:0] rk_data;
  logic [3:0]      rk_index;
  logic            done;

  modport master (
    output start, last_key, rk_ready,
    input  busy, rk_valid, rk_data, rk_index, done
  );

  modport slave (
    input  start, last_key, rk_ready,
    output busy, rk_valid, rk_data, rk_index, done
  );

endinterface

// File: rtl/aes_inv_key_schedule_inv_key_step.sv
// rtl/aes_inv_key_schedule_inv_key_step.sv - combinational step from round key r back to round key r-1
module aes_inv_key_schedule_inv_key_step
  import aes_inv_key_schedule_pkg::*;
(
  input  logic [RK_W-1:0] key_i,
  input  logic [3:0]      rnd_i,
  output logic [RK_W-1:0] key_o
);

  logic [31:0] a, b, c, d;
  logic [31:0] a_n, b_n, c_n, d_n;
  logic [3:0]  rcon_idx;
  logic [31:0] rcon_w;

  assign {a, b, c, d} = key_i;

  // Round 0 is never stepped; clamping keeps the table lookup in range for any rnd_i.
  assign rcon_idx = (rnd_i == 4'd0 || rnd_i > 4'd10) ? 4'd0 : rnd_i - 4'd1;
  assign rcon_w   = {RCON[rcon_idx], 24'h000000};

  assign d_n = d ^ c;
  assign c_n = c ^ b;
  assign b_n = b ^ a;
  assign a_n = a ^ sub_word(rot_word(d_n)) ^ rcon_w;

  assign key_o = {a_n, b_n, c_n, d_n};

endmodule

// File: rtl/aes_inv_key_schedule.sv
// rtl/aes_inv_key_schedule.sv - reverse AES-128 key schedule emitting round keys 10 down to 0
// Optional INV_MIXCOL_KEYS_EN: rounds 1..9 leave through InvMixColumns (equivalent inverse cipher keys).
module aes_inv_key_schedule
  import aes_inv_key_schedule_pkg::*;
#(
  parameter int NR    = ROUNDS,
  parameter int KEY_W = RK_W
) (
  input logic                   clk_i,
  input logic                   rst_i,
  aes_inv_key_schedule_if.slave ks_if
);

  inv_ks_state_t    state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [KEY_W-1:0] key_prev;
  logic [KEY_W-1:0] rk_out;
  logic [3:0]       rnd_q, rnd_d;
  logic             done_q, done_d;
  logic             emit;

  aes_inv_key_schedule_inv_key_step u_inv_key_step (
    .key_i (key_q),
    .rnd_i (rnd_q),
    .key_o (key_prev)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      key_q   <= '0;
      rnd_q   <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ks_if.start) begin
          key_d   = ks_if.last_key;
          rnd_d   = 4'(NR);
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (ks_if.rk_ready) begin
          if (rnd_q != 4'd0) begin
            key_d = key_prev;
            rnd_d = rnd_q - 4'd1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign emit = (state_q == EMIT);

`ifdef INV_MIXCOL_KEYS_EN
  // Output-only transform; the recurrence above always runs on the raw key_q.
  always_comb begin
    rk_out = key_q;
    if (rnd_q != 4'd0 && rnd_q != 4'(NR)) begin
      for (int i = 0; i < 4; i++) begin
        rk_out[32*i +: 32] = inv_mix_column(key_q[32*i +: 32]);
      end
    end
  end
`else
  assign rk_out = key_q;
`endif

  assign ks_if.busy     = emit;
  assign ks_if.rk_valid = emit;
  assign ks_if.rk_data  = emit ? rk_out : '0;
  assign ks_if.rk_index = emit ? rnd_q : 4'd0;
  assign ks_if.done     = done_q;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// tb/tb_aes_inv_key_schedule.sv - scoreboard bench for the reverse AES-128 key schedule
module tb_aes_inv_key_schedule;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] data;
  } exp_t;

`ifdef INV_MIXCOL_KEYS_EN
  localparam bit MIX_EN = 1'b1;
`else
  localparam bit MIX_EN = 1'b0;
`endif

  localparam logic [127:0] A1_LAST = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  // FIPS-197 A.1 round keys, index = round number
  logic [127:0] a1_rk [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  logic [127:0] fwd_rk [0:10];

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  bit   bp_en = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb [$];

  bit           stall = 1'b0;
  bit           pend_done = 1'b0;
  bit           acc_idx0;
  logic [127:0] held_data;
  logic [3:0]   held_idx;
  exp_t         e;

  int t0, t1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_inv_key_schedule_if ifc ();

  aes_inv_key_schedule dut (
    .clk_i (clk),
    .rst_i (rst),
    .ks_if (ifc)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference GF(2^8) multiply: carry-less product then explicit reduction by x^8+x^4+x^3+x+1
  function automatic logic [7:0] m_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'h0000;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
    return prod[7:0];
  endfunction

  function automatic logic [7:0] m_rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] m_sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int c = 1; c < 256; c++) if (m_gmul(x, 8'(c)) == 8'h01) inv = 8'(c);
    return inv ^ m_rotl(inv, 1) ^ m_rotl(inv, 2) ^ m_rotl(inv, 3) ^ m_rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] m_subrot(input logic [31:0] w);
    return {m_sbox(w[23:16]), m_sbox(w[15:8]), m_sbox(w[7:0]), m_sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] m_inv_mix(input logic [127:0] k);
    logic [127:0] r;
    logic [7:0]   s0, s1, s2, s3;
    for (int i = 0; i < 4; i++) begin
      {s0, s1, s2, s3} = k[32*i +: 32];
      r[32*i +: 32] = {m_gmul(8'h0e, s0) ^ m_gmul(8'h0b, s1) ^ m_gmul(8'h0d, s2) ^ m_gmul(8'h09, s3),
                       m_gmul(8'h09, s0) ^ m_gmul(8'h0e, s1) ^ m_gmul(8'h0b, s2) ^ m_gmul(8'h0d, s3),
                       m_gmul(8'h0d, s0) ^ m_gmul(8'h09, s1) ^ m_gmul(8'h0e, s2) ^ m_gmul(8'h0b, s3),
                       m_gmul(8'h0b, s0) ^ m_gmul(8'h0d, s1) ^ m_gmul(8'h09, s2) ^ m_gmul(8'h0e, s3)};
    end
    return r;
  endfunction

  function automatic logic [127:0] exp_rk(input int r, input logic [127:0] k);
    return (MIX_EN && r >= 1 && r <= 9) ? m_inv_mix(k) : k;
  endfunction

  task automatic fwd_expand(input logic [127:0] k0);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = m_subrot(t) ^ {rc, 24'h000000};
        rc = m_gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) fwd_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic push_expected(input logic [127:0] rks [0:10]);
    exp_t x;
    for (int r = 10; r >= 0; r--) begin
      x.idx  = 4'(r);
      x.data = exp_rk(r, rks[r]);
      sb.push_back(x);
    end
  endtask

  task automatic run_start(input logic [127:0] key, output int t_first);
    @(posedge clk);
    #1;
    ifc.start    = 1'b1;
    ifc.last_key = key;
    @(posedge clk);
    #1;
    ifc.start    = 1'b0;
    ifc.last_key = {$urandom(), $urandom(), $urandom(), $urandom()};
    @(negedge clk);
    check("first_valid", ifc.rk_valid, 1'b1);
    t_first = cyc;
  endtask

  task automatic wait_done(input int bound, output int t_done);
    bit seen;
    seen   = 1'b0;
    t_done = -1;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (ifc.done) begin
        seen   = 1'b1;
        t_done = cyc;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no_done required=done_within_%0d_cycles", bound);
    end
  endtask

  initial begin
    forever begin
      #1;
      @(posedge clk);
      #1;
      ifc.rk_ready = bp_en ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every accept and polices stalls and the done pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        stall     = 1'b0;
        pend_done = 1'b0;
      end else begin
        if (stall) begin
          check("stall_valid", ifc.rk_valid, 1'b1);
          check("stall_data", ifc.rk_data, held_data);
          check("stall_index", ifc.rk_index, held_idx);
        end
        if (pend_done || ifc.done) check("done_pulse", ifc.done, pend_done);
        if (ifc.rk_valid) check("busy_with_valid", ifc.busy, 1'b1);
        acc_idx0 = 1'b0;
        if (ifc.rk_valid && ifc.rk_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_accept actual=idx%0d required=no_key", ifc.rk_index);
          end else begin
            e = sb.pop_front();
            check("rk_index", ifc.rk_index, e.idx);
            check("rk_data", ifc.rk_data, e.data);
            acc_idx0 = (e.idx == 4'd0);
          end
        end
        pend_done = acc_idx0;
        stall     = ifc.rk_valid && !ifc.rk_ready;
        held_data = ifc.rk_data;
        held_idx  = ifc.rk_index;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.start    = 1'b0;
    ifc.last_key = '0;
    ifc.rk_ready = 1'b1;
    fwd_expand(128'h000102030405060708090a0b0c0d0e0f);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", ifc.busy, 1'b0);
    check("reset_rk_valid", ifc.rk_valid, 1'b0);
    check("reset_rk_data", ifc.rk_data, 128'h0);
    check("reset_rk_index", ifc.rk_index, 4'd0);
    check("reset_done", ifc.done, 1'b0);
    rst = 1'b0;

    // full sequence with rk_ready held high
    push_expected(a1_rk);
    run_start(A1_LAST, t0);
    wait_done(60, t1);
    check("done_latency", t1 - t0, 11);
    check("drain_full", sb.size(), 0);

    // random backpressure
    bp_en = 1'b1;
    push_expected(a1_rk);
    run_start(A1_LAST, t0);
    wait_done(600, t1);
    bp_en = 1'b0;
    check("drain_backpressure", sb.size(), 0);

    // start during a run must be ignored
    push_expected(a1_rk);
    run_start(A1_LAST, t0);
    repeat (3) @(posedge clk);
    #1;
    ifc.start    = 1'b1;
    ifc.last_key = fwd_rk[10];
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    wait_done(60, t1);
    check("drain_ignored_start", sb.size(), 0);

    // reset mid-run at rk_index 5
    push_expected(a1_rk);
    run_start(A1_LAST, t0);
    t1 = 0;
    for (int i = 0; i < 40 && t1 == 0; i++) begin
      @(negedge clk);
      if (ifc.rk_valid && ifc.rk_index == 4'd5) t1 = 1;
    end
    check("reached_index5", t1, 1);
    #2 rst = 1'b1;
    #1;
    check("midrun_rst_valid", ifc.rk_valid, 1'b0);
    check("midrun_rst_busy", ifc.busy, 1'b0);
    check("midrun_rst_data", ifc.rk_data, 128'h0);
    check("midrun_rst_index", ifc.rk_index, 4'd0);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    push_expected(a1_rk);
    run_start(A1_LAST, t0);
    wait_done(60, t1);
    check("drain_after_reset", sb.size(), 0);

    // back-to-back: second start issued during the done cycle
    push_expected(a1_rk);
    run_start(A1_LAST, t0);
    wait_done(60, t1);
    push_expected(fwd_rk);
    ifc.start    = 1'b1;
    ifc.last_key = fwd_rk[10];
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    @(negedge clk);
    check("b2b_first_valid", ifc.rk_valid, 1'b1);
    t0 = cyc;
    wait_done(60, t1);
    check("b2b_done_latency", t1 - t0, 11);
    check("drain_b2b", sb.size(), 0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
